// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the iterative shift unit:
// op encodings, FSM states and stage count.
package shift_sequencer_pkg;

    localparam int SHIFT_STAGES = 5;

    localparam logic [1:0] SHIFT_SLL = 2'b00;
    localparam logic [1:0] SHIFT_SRL = 2'b01;
    localparam logic [1:0] SHIFT_SRA = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_sequencer_if.sv
// Start/ready handshake and data bus of the shift unit.
// master = issuing control logic, slave = shift unit.
interface shift_sequencer_if;

    logic        ctrl_start;
    logic [1:0]  ctrl_op;
    logic [4:0]  ctrl_shiftamt;
    logic [31:0] data_operandA;
    logic [31:0] data_result;
    logic        data_resultRDY;
    logic        busy;

    modport master (
        output ctrl_start,
        output ctrl_op,
        output ctrl_shiftamt,
        output data_operandA,
        input  data_result,
        input  data_resultRDY,
        input  busy
    );

    modport slave (
        input  ctrl_start,
        input  ctrl_op,
        input  ctrl_shiftamt,
        input  data_operandA,
        output data_result,
        output data_resultRDY,
        output busy
    );

endinterface

// File: rtl/shift_sequencer_stage_var.sv
// One selectable power-of-two shift stage (2^k, k = 0..4).
// Reserved op 2'b11 falls through to a left shift.
module shift_stage_var
    import shift_sequencer_pkg::*;
(
    input  logic [31:0] i_data,
    input  logic [2:0]  i_k,
    input  logic        i_en,
    input  logic [1:0]  i_op,
    input  logic        i_sign,
    output logic [31:0] o_data
);

    logic        w_right;
    logic        w_fbit;
    logic [31:0] w_s1;
    logic [31:0] w_s2;
    logic [31:0] w_s4;
    logic [31:0] w_s8;
    logic [31:0] w_s16;
    logic [31:0] w_sh;

    assign w_right = (i_op == SHIFT_SRL) || (i_op == SHIFT_SRA);
    assign w_fbit  = (i_op == SHIFT_SRA) ? i_sign : 1'b0;

    assign w_s1  = w_right ? {{1{w_fbit}},  i_data[31:1]}
                           : {i_data[30:0], 1'b0};
    assign w_s2  = w_right ? {{2{w_fbit}},  i_data[31:2]}
                           : {i_data[29:0], 2'b0};
    assign w_s4  = w_right ? {{4{w_fbit}},  i_data[31:4]}
                           : {i_data[27:0], 4'b0};
    assign w_s8  = w_right ? {{8{w_fbit}},  i_data[31:8]}
                           : {i_data[23:0], 8'b0};
    assign w_s16 = w_right ? {{16{w_fbit}}, i_data[31:16]}
                           : {i_data[15:0], 16'b0};

    always_comb begin
        w_sh = i_data;
        case (i_k)
            3'd0:    w_sh = w_s1;
            3'd1:    w_sh = w_s2;
            3'd2:    w_sh = w_s4;
            3'd3:    w_sh = w_s8;
            3'd4:    w_sh = w_s16;
            default: w_sh = i_data;
        endcase
    end

    assign o_data = i_en ? w_sh : i_data;

endmodule

// File: rtl/shift_sequencer.sv
// Iterative 32-bit shifter: one 2^k stage per clock,
// fixed 5-cycle latency, start/ready handshake.
module shift_sequencer
    import shift_sequencer_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    shift_sequencer_if.slave   bus
);

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_k;
    logic [1:0]  r_op;
    logic [4:0]  r_shamt;
    logic        r_sign;
    logic [31:0] r_work;
    logic [31:0] w_stage;
    logic        w_accept;
    logic        w_en;
    logic        w_last;

    assign w_last = (r_k == 3'(SHIFT_STAGES - 1));
    assign w_en   = (r_k < 3'(SHIFT_STAGES)) ? r_shamt[r_k] : 1'b0;

    shift_stage_var u_stage (
        .i_data (r_work),
        .i_k    (r_k),
        .i_en   (w_en),
        .i_op   (r_op),
        .i_sign (r_sign),
        .o_data (w_stage)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.ctrl_start) begin
                    w_accept = 1'b1;
                    w_next   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_last) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_accept = bus.ctrl_start;
                w_next   = bus.ctrl_start ? ST_SHIFT : ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Starts arriving during SHIFT are dropped here by design.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_k     <= 3'd0;
            r_op    <= SHIFT_SLL;
            r_shamt <= 5'd0;
            r_sign  <= 1'b0;
            r_work  <= 32'h0;
        end else if (w_accept) begin
            r_k     <= 3'd0;
            r_op    <= bus.ctrl_op;
            r_shamt <= bus.ctrl_shiftamt;
            r_sign  <= bus.data_operandA[31];
            r_work  <= bus.data_operandA;
        end else if (r_state == ST_SHIFT) begin
            r_k    <= r_k + 3'd1;
            r_work <= w_stage;
        end
    end

    assign bus.data_result    = r_work;
    assign bus.data_resultRDY = (r_state == ST_DONE);
    assign bus.busy           = (r_state == ST_SHIFT);

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Iterative 32-bit shift unit for the CPU execute stage: latches an operand, a 5-bit shift amount and a shift type, then applies one power-of-two shift stage per clock (1, 2, 4, 8, 16) until the full amount is done. It takes operands directly from the ALU operand path. Its result goes to the writeback mux. It trades the single-cycle barrel-shifter area for a fixed 5-cycle latency. A start/ready handshake matches the multdiv unit, so control logic can stall on either unit the same way.

## Interface
- No parameters; data width is fixed at 32, shift-amount width at 5.
- clock  input  1  — single clock; all state updates on rising edge.
- reset  input  1  — asynchronous, active-low; clears all state immediately.
- ctrl_start  input  1  — request pulse; sampled on rising edge.
- ctrl_op  input  2  — shift type: 00 SLL, 01 SRL, 10 SRA, 11 reserved (executes as SLL).
- ctrl_shiftamt  input  5  — shift amount 0..31.
- data_operandA  input  32  — value to shift.
- data_result  output  32  — shifted value; holds until the next accepted start.
- data_resultRDY  output  1  — one-cycle pulse: data_result is valid.
- busy  output  1  — high while a shift is in progress.

## Operation
- States: IDLE, SHIFT, DONE.
- **IDLE** — waits for a start:
  - When ctrl_start=1: latch data_operandA into the working register, and latch ctrl_shiftamt and ctrl_op.
  - Clear the stage index k to 0 and go to SHIFT.
- **SHIFT** — one stage per cycle:
  - Each cycle: if shamt_latched[k]=1, shift the working register by 2^k per op; otherwise hold it. Then k increments.
  - Shift fill: SLL fills zeros from the LSB side. SRL fills zeros from the MSB side. SRA replicates the latched operand's bit 31.
  - After the k=4 stage the next state is DONE.
- **DONE** — present the result:
  - data_resultRDY=1 for exactly this cycle; data_result equals the working register.
  - If ctrl_start=1, latch the new request and go to SHIFT (back-to-back accept). Otherwise go to IDLE.
- ctrl_start while in SHIFT is ignored; no queuing.
- Latency is always 5 stage cycles, including shamt=0. With shamt=0 the result equals the operand.
- busy=1 in SHIFT, 0 in IDLE and DONE.
- Reset mid-operation aborts the operation; no RDY pulse is produced for the aborted request.

## Timing
- Reset values: data_result=32'h0, data_resultRDY=0, busy=0, state=IDLE, k=0.
- Start sampled at edge E0: busy goes high after E0.
- Stages for shift amounts 1, 2, 4, 8, 16 are applied at edges E1..E5. The state enters DONE after E5.
- data_resultRDY is high from E5 to E6.
- Next start may be sampled at E5+1 (during DONE) at the earliest. Throughput is one shift per 6 cycles.
- data_result changes only at stage edges; it is stable from E5 until the next accepted start plus one edge.
- Intermediate working-register values are visible on data_result during SHIFT. Consumers must qualify with data_resultRDY.
- Inputs need only be valid at the start edge; they are don't-care afterward.

## Structure
- Shared CPU package holds:
  - the ctrl_op encodings (SHIFT_SLL=2'b00, SHIFT_SRL=2'b01, SHIFT_SRA=2'b10);
  - the state encoding;
  - SHIFT_STAGES=5.
- Sub-module **shift_stage_var**: combinational, 32-bit in/out, inputs k (3 bits), enable and op, output one 2^k shift. It is built from per-amount mux ranks like the existing fixed-amount shift stages.
- The top level holds the FSM, the stage counter, the latched op/shamt/sign bit, and the working register.

## Test plan
- SLL, operand 32'h00000001, shamt 4: data_resultRDY pulses 5 edges after start; data_result=32'h00000010; busy high for the 5 cycles in between.
- SRA, operand 32'h80000000, shamt 31: result=32'hFFFFFFFF. SRL with the same inputs: result=32'h00000001.
- shamt 0, op SRA, operand 32'hDEADBEEF: result=32'hDEADBEEF, same 5-cycle latency.
- Back-to-back, SLL 32'h1 by 1 then SLL 32'h1 by 31 (second start issued during DONE):
  - first RDY carries 32'h2, second RDY carries 32'h80000000;
  - RDY pulses are 6 cycles apart.
- Start during SHIFT (second request, SLL 32'hFFFFFFFF by 8) is ignored: only one RDY pulse, carrying the first request's result.
- reset driven low at E3 of an operation:
  - outputs go to 0 immediately (asynchronously), with no RDY pulse;
  - after reset is released, a new SRL 32'hF0000000 by 28 returns 32'h0000000F.
